// File: rtl/fx_alu_pkg.sv
// Shared types and helpers for the sequential fixed-point ALU.
// Optional build macro: FX_ALU_SAT_EN (saturate results on overflow).
package fx_alu_pkg;

  // Widest magnitude the overflow helper handles (2*N bits, so N <= 64).
  localparam int unsigned FX_MAX_W = 128;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_MUL = 2'b10,
    ALU_DIV = 2'b11
  } op_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  typedef struct packed {
    logic ovf;
    logic div_zero;
  } fx_flags_t;

  // True when an unsigned magnitude cannot be represented as an n-bit
  // two's-complement value with the given sign (negative side reaches 2^(n-1)).
  function automatic logic fx_mag_ovf(input logic [FX_MAX_W-1:0] mag,
                                      input logic                neg,
                                      input int unsigned         n);
    logic [FX_MAX_W-1:0] lim;
    lim = FX_MAX_W'(1) << (n - 1);
    if (!neg) begin
      lim = lim - FX_MAX_W'(1);
    end
    return mag > lim;
  endfunction

endpackage

// File: rtl/fx_div_iter.sv
// Restoring divider: (dvd_mag << FRAC) / dvs_mag, one quotient bit per cycle.
// done_o flags the cycle whose edge writes the final quotient bit.
module fx_div_iter
  import fx_alu_pkg::*;
#(
  parameter int unsigned N    = 32,
  parameter int unsigned FRAC = N / 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic [N-1:0]        dvd_mag_i,
  input  logic [N-1:0]        dvs_mag_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [N+FRAC-1:0]   quo_o
);

  localparam int unsigned QW = N + FRAC;
  localparam int unsigned CW = $clog2(QW + 1);

  logic [QW-1:0] dvd_q;
  logic [N-1:0]  dvs_q;
  logic [N-1:0]  rem_q;
  logic [QW-1:0] quo_q;
  logic [CW-1:0] cnt_q;

  logic [N:0]    trial;
  logic [N:0]    dvs_ext;
  logic          qbit;
  logic [N-1:0]  rem_nxt;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    trial   = {rem_q, dvd_q[QW-1]};
    dvs_ext = {1'b0, dvs_q};
    qbit    = (trial >= dvs_ext);
    rem_nxt = qbit ? N'(trial - dvs_ext) : N'(trial);
  end

  // Iteration registers; reset also clears the counter so a mid-op reset aborts.
  always_ff @(posedge clk) begin
    if (rst) begin
      dvd_q <= '0;
      dvs_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
      cnt_q <= '0;
    end else if (start_i) begin
      dvd_q <= QW'(dvd_mag_i) << FRAC;
      dvs_q <= dvs_mag_i;
      rem_q <= '0;
      quo_q <= '0;
      cnt_q <= CW'(QW);
    end else if (cnt_q != '0) begin
      dvd_q <= dvd_q << 1;
      rem_q <= rem_nxt;
      quo_q <= {quo_q[QW-2:0], qbit};
      cnt_q <= cnt_q - CW'(1);
    end
  end

  assign busy_o = (cnt_q != '0);
  assign done_o = (cnt_q == CW'(1));
  assign quo_o  = quo_q;

endmodule

// File: rtl/fx_alu_seq.sv
// Sequential signed fixed-point ALU (ADD/SUB/MUL/DIV) with valid/ready on both sides.
// Optional build macro: FX_ALU_SAT_EN clamps overflowed results instead of wrapping.
module fx_alu_seq
  import fx_alu_pkg::*;
#(
  parameter int unsigned N    = 32,
  parameter int unsigned FRAC = N / 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [1:0]   op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic         ovf,
  output logic         div_zero
);

  localparam int unsigned QW = N + FRAC;
  localparam int unsigned PW = 2 * N;
  localparam logic [N-1:0] MAX_POS = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] MIN_NEG = {1'b1, {(N-1){1'b0}}};

  function automatic logic [N-1:0] mag_of(input logic [N-1:0] x);
    return x[N-1] ? (~x + N'(1)) : x;
  endfunction

  function automatic logic [N-1:0] apply_sign(input logic [N-1:0] m, input logic neg);
    return neg ? (~m + N'(1)) : m;
  endfunction

  state_t       state_q, state_d;
  logic [N-1:0] a_q, b_q;
  logic [N-1:0] result_q, result_d;
  fx_flags_t    flags_q, flags_d;
  logic         out_valid_q, out_valid_d;

  op_t          op_in;
  logic         accept;
  logic         b_zero;
  logic [N-1:0] sum, diff;
  logic         add_ovf, sub_ovf;

  logic [N-1:0] mul_ma, mul_mb;
  logic [PW-1:0] mul_prod, mul_sh;
  logic         mul_neg, mul_ovf;

  logic         div_start, div_busy, div_done;
  logic [QW-1:0] div_quo;
  logic         div_neg, div_ovf;

  logic         load;
  logic [N-1:0] sel_wrap, sel_res, sat_val;
  logic         sel_ovf, sel_neg, sel_dz;

  assign op_in    = op_t'(op);
  assign in_ready = (state_q == ST_IDLE) && !rst;
  assign accept   = in_valid && in_ready;
  assign b_zero   = (b == '0);

  // ADD/SUB operate directly on the accepted beat.
  always_comb begin
    sum     = a + b;
    diff    = a - b;
    add_ovf = (a[N-1] == b[N-1]) && (sum[N-1] != a[N-1]);
    sub_ovf = (a[N-1] != b[N-1]) && (diff[N-1] != a[N-1]);
  end

  // MUL on latched operands: unsigned magnitude product, truncated by FRAC.
  always_comb begin
    mul_ma   = mag_of(a_q);
    mul_mb   = mag_of(b_q);
    mul_neg  = a_q[N-1] ^ b_q[N-1];
    mul_prod = PW'(mul_ma) * PW'(mul_mb);
    mul_sh   = mul_prod >> FRAC;
    mul_ovf  = fx_mag_ovf(FX_MAX_W'(mul_sh), mul_neg, N);
  end

  // DIV sign/overflow on the finished unsigned quotient.
  always_comb begin
    div_neg = a_q[N-1] ^ b_q[N-1];
    div_ovf = fx_mag_ovf(FX_MAX_W'(div_quo), div_neg, N);
  end

  assign div_start = accept && (op_in == ALU_DIV) && !b_zero;

  fx_div_iter #(
    .N    (N),
    .FRAC (FRAC)
  ) u_div (
    .clk       (clk),
    .rst       (rst),
    .start_i   (div_start),
    .dvd_mag_i (mag_of(a)),
    .dvs_mag_i (mag_of(b)),
    .busy_o    (div_busy),
    .done_o    (div_done),
    .quo_o     (div_quo)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          unique case (op_in)
            ALU_ADD, ALU_SUB: state_d = ST_DONE;
            ALU_MUL:          state_d = ST_MUL;
            ALU_DIV:          state_d = b_zero ? ST_DONE : ST_DIV;
            default:          state_d = ST_IDLE;
          endcase
        end
      end
      ST_MUL:  state_d = ST_DONE;
      ST_DIV:  if (div_busy && div_done) state_d = ST_FIX;
      ST_FIX:  state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output next values: pick the finishing operation, then wrap or clamp.
  always_comb begin
    load     = 1'b0;
    sel_wrap = '0;
    sel_ovf  = 1'b0;
    sel_neg  = 1'b0;
    sel_dz   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          unique case (op_in)
            ALU_ADD: begin
              load = 1'b1; sel_wrap = sum;  sel_ovf = add_ovf; sel_neg = a[N-1];
            end
            ALU_SUB: begin
              load = 1'b1; sel_wrap = diff; sel_ovf = sub_ovf; sel_neg = a[N-1];
            end
            ALU_DIV: begin
              if (b_zero) begin
                load = 1'b1; sel_ovf = 1'b1; sel_dz = 1'b1; sel_neg = a[N-1];
              end
            end
            default: ;
          endcase
        end
      end
      ST_MUL: begin
        load     = 1'b1;
        sel_wrap = apply_sign(mul_sh[N-1:0], mul_neg);
        sel_ovf  = mul_ovf;
        sel_neg  = mul_neg;
      end
      ST_FIX: begin
        load     = 1'b1;
        sel_wrap = apply_sign(div_quo[N-1:0], div_neg);
        sel_ovf  = div_ovf;
        sel_neg  = div_neg;
      end
      default: ;
    endcase

    sat_val = sel_neg ? MIN_NEG : MAX_POS;
    sel_res = sel_dz ? sat_val : sel_wrap;
`ifdef FX_ALU_SAT_EN
    if (sel_ovf) begin
      sel_res = sat_val;
    end
`endif

    result_d         = load ? sel_res : result_q;
    flags_d.ovf      = load ? sel_ovf : flags_q.ovf;
    flags_d.div_zero = load ? sel_dz  : flags_q.div_zero;
    out_valid_d      = (state_d == ST_DONE);
  end

  // Operand capture on accept only.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
    end else if (accept) begin
      a_q <= a;
      b_q <= b;
    end
  end

  // Registered outputs, held stable through DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q    <= '0;
      flags_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      result_q    <= result_d;
      flags_q     <= flags_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign result    = result_q;
  assign ovf       = flags_q.ovf;
  assign div_zero  = flags_q.div_zero;
  assign out_valid = out_valid_q;

endmodule

// File: doc/fx_alu_seq.md
# fx_alu_seq

Sequential, parametrised signed fixed-point ALU that replaces the single-cycle combinational fixed-point ALU in the physics datapath. It supports ADD/SUB/MUL/DIV over an N-bit two's-complement Qm.FRAC format and uses a valid/ready handshake on both sides. Division is iterative and exact (one quotient bit per cycle) rather than a reciprocal approximation. It sits between the integrator's operand scheduler and its writeback stage, with one operation in flight at a time.

## Interface
- N, default 32: operand/result width, two's complement, N ≥ 8.
- FRAC, default N/2: fraction bits, 1 ≤ FRAC ≤ N-2.
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept an operation.
- a, b  in  N  signed fixed-point operands.
- op  in  2  00 ADD, 01 SUB, 10 MUL, 11 DIV.
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  consumer accepts result.
- result  out  N  signed fixed-point result.
- ovf  out  1  result overflowed the N-bit range (valid with out_valid).
- div_zero  out  1  DIV with b == 0 (valid with out_valid).

## Operation
- FSM states: IDLE, MUL, DIV, FIX, DONE.
- in_ready = (state == IDLE) && !rst.
- Accept occurs when in_valid && in_ready. Operands and op are latched on accept and are ignored at all other times.
- ADD/SUB: result = a ± b mod 2^N. ovf = signed overflow. IDLE→DONE.
- MUL: sign s = a[N-1]^b[N-1]. The magnitudes are N-bit unsigned, so -2^(N-1) is handled. The 2N-bit magnitude product is shifted right by FRAC (truncation toward zero), then negated if s.
  - ovf is set when the shifted magnitude exceeds 2^(N-1)-1, or 2^(N-1) when s is set.
  - IDLE→MUL→DONE.
- DIV: restoring division of |a|<<FRAC (N+FRAC bits) by |b|, one quotient bit per cycle for N+FRAC cycles. The quotient is truncated toward zero, then sign-corrected in FIX.
  - ovf uses the same rule as MUL.
  - IDLE→DIV→FIX→DONE.
- DIV with b == 0: no iteration. div_zero=1 and ovf=1. result = 2^(N-1)-1 if a ≥ 0, else -2^(N-1). IDLE→DONE.
- DONE: out_valid=1, and result/ovf/div_zero are stable. out_valid && out_ready → IDLE. The next accept is possible one cycle later (no same-cycle turnaround).
- Reset (any state, including mid-DIV): next edge forces state=IDLE, out_valid=0, result=0, ovf=0, div_zero=0, and iteration counter=0. The in-flight operation is discarded with no output.

## Timing
- Latency is counted from the accepting edge to the first edge at which out_valid is seen high:
  - ADD/SUB: 1.
  - MUL: 2.
  - DIV (b≠0): N+FRAC+2. This is 50 for N=32, FRAC=16.
  - DIV (b=0): 1.
- Throughput: one operation per (latency + 1) cycles when out_ready is held high.
- Outputs are registered. No combinational path exists from in_* to out_* or from out_ready to in_ready.

## Configuration
- FX_ALU_SAT_EN defined: on ovf, result clamps to 2^(N-1)-1 for positive true results and -2^(N-1) for negative ones. This applies to ADD, SUB, MUL and DIV.
- FX_ALU_SAT_EN undefined: on ovf, result is the low N bits of the sign-applied value, which wraps (legacy behaviour). ovf is still reported.
- div_zero result clamping applies in both builds.

## Structure
- Package fx_alu_pkg holds:
  - op_t enum (ALU_ADD/SUB/MUL/DIV, matching the 2-bit encoding).
  - state_t enum.
  - Helper function for the ovf/saturation decision.
- Sub-module fx_div_iter: restoring divider holding remainder, quotient and counter. It has start/busy/done, and takes magnitudes in and returns the unsigned quotient out. It is parametrised on N and FRAC and reset by the same rst.
- Top-level fx_alu_seq holds the FSM, sign handling, the MUL datapath and the output registers.

## Test plan
Cases use N=32, FRAC=16.
- MUL 3.0×2.0: a=0x0003_0000, b=0x0002_0000 → result=0x0006_0000, ovf=0, out_valid 2 cycles after accept.
- DIV 1.0/−4.0: a=0x0001_0000, b=0xFFFC_0000 → result=0xFFFF_C000, out_valid exactly 50 cycles after accept. in_ready=0 throughout.
- DIV by zero: a=0xFFFF_0000, b=0 → result=0x8000_0000, div_zero=1, ovf=1, latency 1.
- MUL overflow: a=b=0x0100_0000 → ovf=1.
  - With FX_ALU_SAT_EN: result=0x7FFF_FFFF.
  - Without it: result=0x0000_0000.
- ADD with backpressure: a=0x7FFF_0000, b=0x0001_0000, out_ready low for 5 cycles → result held constant and in_ready=0 while held.
  - With FX_ALU_SAT_EN: result=0x7FFF_FFFF, ovf=1.
  - Without it: result=0x8000_0000, ovf=1.
  - When out_ready rises: completes, and in_ready rises the next cycle.
- Reset mid-DIV: assert rst 10 cycles into a DIV → next edge out_valid=0, result=0, in_ready=1 after rst deasserts. A following ADD 0x0001_0000+0x0001_0000 returns 0x0002_0000.
